// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-requester arbiter/sequencer for a single-port synchronous
//             RAM with registered read data. Round-robin by default; define
//             RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          pick1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    logic last_q, last_d;
    // On a tie the requester not served most recently wins.
    assign pick1 = req1 & (~req0 | ~last_q);
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    sel_d   = pick1;
                    addr_d  = pick1 ? addr1 : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    state_d = (pick1 ? we1 : we0) ? WR : RD;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    last_d  = pick1;
`endif
                end
            end
            WR:   state_d = IDLE;
            RD:   state_d = RESP;
            RESP: begin
                if (sel_q) begin
                    rdata1_d  = ram_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = ram_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    // Decoded from state so reset drops ram_we without waiting for a clock.
    assign ram_we    = (state_q == WR);
    assign gnt0      = ((state_q == WR) || (state_q == RD)) && !sel_q;
    assign gnt1      = ((state_q == WR) || (state_q == RD)) &&  sel_q;
    assign busy      = (state_q != IDLE);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed self-checking bench for ram_arbiter with a 16x8 RAM
//             model (registered read). Honours RAM_ARB_FIXED_PRIO_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;

    int checks;
    int failures;

    logic [7:0] mem [16];

    ram_arbiter #(.DW(8), .AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full requester-0 transaction with cycle-exact checks; starts at a negedge.
    task automatic txn0(input logic we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp);
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        @(negedge clk);
        chk("txn_gnt0", gnt0, 1);
        chk("txn_gnt1", gnt1, 0);
        chk("txn_ram_we", ram_we, we);
        chk("txn_ram_addr", ram_addr, a);
        if (we) chk("txn_ram_wdata", ram_wdata, d);
        req0 = 1'b0;
        @(negedge clk);
        chk("txn_gnt0_off", gnt0, 0);
        chk("txn_ram_we_off", ram_we, 0);
        if (!we) begin
            chk("txn_busy_resp", busy, 1);
            chk("txn_rvalid_early", rvalid0, 0);
            @(negedge clk);
            chk("txn_rvalid0", rvalid0, 1);
            chk("txn_rdata0", rdata0, exp);
        end else begin
            chk("txn_busy_idle", busy, 0);
        end
    endtask

    task automatic wait_gnt(output int who);
        who = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt0) begin who = 0; break; end
            if (gnt1) begin who = 1; break; end
        end
        if (who < 0) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rvalid(input int r);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((r == 0) ? rvalid0 : rvalid1) begin seen = 1'b1; break; end
        end
        chk("rvalid_timeout", seen, 1);
    endtask

    logic [7:0] wvals [5];
    int         grants [$];
    int         who;
    int         extra;

    initial begin
        checks = 0; failures = 0;
        wvals[0] = 8'd55; wvals[1] = 8'd99; wvals[2] = 8'd150;
        wvals[3] = 8'd200; wvals[4] = 8'd77;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_rvalid", {rvalid0, rvalid1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Requester 0: five writes then five reads back.
        for (int i = 0; i < 5; i++) txn0(1'b1, 4'(i), wvals[i], 8'h00);
        for (int i = 0; i < 5; i++) txn0(1'b0, 4'(i), 8'h00, wvals[i]);

        // Both requesters reading continuously straight after reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd1;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (gnt0) grants.push_back(0);
            else if (gnt1) grants.push_back(1);
        end
        chk("both_grant_count", grants.size(), 4);
        while (grants.size() < 4) grants.push_back(-1);
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("fixed_g0", grants[0], 0);
        chk("fixed_g1", grants[1], 0);
        chk("fixed_g2", grants[2], 0);
        chk("fixed_g3", grants[3], 0);
`else
        chk("rr_g0", grants[0], 0);
        chk("rr_g1", grants[1], 1);
        chk("rr_g2", grants[2], 0);
        chk("rr_g3", grants[3], 1);
`endif
        req0 = 1'b0;
        wait_gnt(who);
        chk("after_req0_drop", who, 1);
        req1 = 1'b0;
        wait_rvalid(1);
        chk("rdata1_addr1", rdata1, 8'd99);

        // Leave last = 0 so requester 1 wins the next tie.
        txn0(1'b0, 4'd0, 8'h00, 8'd55);

        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd15;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd15; wdata1 = 8'hA5;
        wait_gnt(who);
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("tie_first_fixed", who, 0);
        req0 = 1'b0;
        wait_gnt(who);
        chk("tie_second_fixed", who, 1);
        req1 = 1'b0;
`else
        chk("tie_first_rr", who, 1);
        req1 = 1'b0;
        wait_gnt(who);
        chk("tie_second_rr", who, 0);
        req0 = 1'b0;
        wait_rvalid(0);
        chk("tie_rdata0", rdata0, 8'hA5);
`endif
        @(negedge clk);
        txn0(1'b0, 4'd15, 8'h00, 8'hA5);

        // Reset landing in RESP of a read.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        @(negedge clk);
        chk("rr_mid_gnt0", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        chk("mid_in_resp", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ram_we", ram_we, 0);
        chk("mid_rst_rdata0", rdata0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_rvalid", rvalid0, 0);
        chk("mid_rst_idle", busy, 0);
        txn0(1'b0, 4'd3, 8'h00, 8'd200);

        // Requester 1 holds req through gnt1 and drops it one cycle later.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        @(negedge clk);
        chk("hold_gnt1", gnt1, 1);
        @(negedge clk);
        chk("hold_gnt1_off", gnt1, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("hold_rvalid1", rvalid1, 1);
        chk("hold_rdata1", rdata1, 8'd150);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (gnt1) extra++;
        end
        chk("hold_no_dup_gnt1", extra, 0);
        chk("hold_final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
